// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Fetches two-byte instructions (opcode at PC, argument at PC+1) from a
//   program memory with one-cycle read latency and queues them in a small
//   instruction buffer for a downstream consumer. A jump request flushes the
//   buffer and redirects the program counter to an even address.
//
//   Configuration macro: FETCH_PREFETCH_EN
//     defined   -> buffer depth 2 (prefetch the next instruction)
//     undefined -> buffer depth 1 (next fetch starts after the head is popped)
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset
//   FETCH_EN     in   permits new instruction fetches
//   MEM_RD       out  program-memory read strobe (registered)
//   MEM_ADDR     out  program-memory byte address (registered, held when idle)
//   MEM_DATA     in   read data, valid the cycle after MEM_RD
//   JUMP_REQ     in   redirect request
//   JUMP_ADDR    in   redirect target (bit 0 ignored)
//   INSTR_OUT    out  opcode of oldest buffered instruction
//   ARG_OUT      out  argument of oldest buffered instruction
//   PC_OUT       out  address of oldest buffered opcode
//   INSTR_VALID  out  buffer is non-empty
//   INSTR_READY  in   consumer accepts the head instruction
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  FETCH_EN,
    output logic                  MEM_RD,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    input  logic                  JUMP_REQ,
    input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
    output logic [DATA_WIDTH-1:0] INSTR_OUT,
    output logic [DATA_WIDTH-1:0] ARG_OUT,
    output logic [ADDR_WIDTH-1:0] PC_OUT,
    output logic                  INSTR_VALID,
    input  logic                  INSTR_READY
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_OP  = 3'd1,
        FETCH_ARG = 3'd2,
        CAPTURE   = 3'd3,
        WAIT      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [1:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    // Slot 0 is always the buffer head; slot 1 shifts into it on a pop.
    logic [DATA_WIDTH-1:0]   op0_q, op0_d, op1_q, op1_d;
    logic [DATA_WIDTH-1:0]   arg0_q, arg0_d, arg1_q, arg1_d;
    logic [ADDR_WIDTH-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;

    logic                    pop_s;
    logic                    push_s;
    logic [1:0]              count_pop_s;

    // Next-state, buffer update and registered memory-interface decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        opcode_d    = opcode_q;
        op0_d       = op0_q;
        arg0_d      = arg0_q;
        pc0_d       = pc0_q;
        op1_d       = op1_q;
        arg1_d      = arg1_q;
        pc1_d       = pc1_q;
        pop_s       = (count_q != 2'd0) && INSTR_READY;
        push_s      = (state_q == CAPTURE);
        count_pop_s = count_q - {1'b0, pop_s};

        if (JUMP_REQ) begin
            // Jump overrides any pop or capture on this edge.
            count_d  = 2'd0;
            pc_d     = JUMP_ADDR & ~ADDR_ONE;
            opcode_d = {DATA_WIDTH{1'b0}};
            state_d  = FETCH_EN ? FETCH_OP : IDLE;
        end else begin
            if (pop_s) begin
                op0_d  = op1_q;
                arg0_d = arg1_q;
                pc0_d  = pc1_q;
            end else begin
                op0_d  = op0_q;
            end
            // Write lands on the first free slot after the pop; a simultaneous
            // pop of a single entry makes that slot 0.
            if (push_s) begin
                if (count_pop_s == 2'd0) begin
                    op0_d  = opcode_q;
                    arg0_d = MEM_DATA;
                    pc0_d  = pc_q;
                end else begin
                    op1_d  = opcode_q;
                    arg1_d = MEM_DATA;
                    pc1_d  = pc_q;
                end
            end else begin
                op1_d = op1_q;
            end
            count_d = count_pop_s + {1'b0, push_s};

            case (state_q)
                IDLE: begin
                    if (FETCH_EN && (count_q < DEPTH)) state_d = FETCH_OP;
                    else                               state_d = IDLE;
                end
                FETCH_OP: begin
                    state_d = FETCH_ARG;
                end
                FETCH_ARG: begin
                    opcode_d = MEM_DATA;
                    state_d  = CAPTURE;
                end
                CAPTURE: begin
                    pc_d = pc_q + ADDR_TWO;
                    if (!FETCH_EN)             state_d = IDLE;
                    else if (count_d < DEPTH)  state_d = FETCH_OP;
                    else                       state_d = WAIT;
                end
                WAIT: begin
                    if (!FETCH_EN)             state_d = IDLE;
                    else if (count_q < DEPTH)  state_d = FETCH_OP;
                    else                       state_d = WAIT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Memory strobe/address are registered from the next state, so the
        // ports carry no combinational path from any input.
        case (state_d)
            FETCH_OP: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = pc_d;
            end
            FETCH_ARG: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = pc_d + ADDR_ONE;
            end
            default: begin
                mem_rd_d   = 1'b0;
                mem_addr_d = mem_addr_q;
            end
        endcase
    end

    // State, PC, buffer and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= {ADDR_WIDTH{1'b0}};
            count_q    <= 2'd0;
            opcode_q   <= {DATA_WIDTH{1'b0}};
            mem_rd_q   <= 1'b0;
            mem_addr_q <= {ADDR_WIDTH{1'b0}};
            op0_q      <= {DATA_WIDTH{1'b0}};
            arg0_q     <= {DATA_WIDTH{1'b0}};
            pc0_q      <= {ADDR_WIDTH{1'b0}};
            op1_q      <= {DATA_WIDTH{1'b0}};
            arg1_q     <= {DATA_WIDTH{1'b0}};
            pc1_q      <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            opcode_q   <= opcode_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            op0_q      <= op0_d;
            arg0_q     <= arg0_d;
            pc0_q      <= pc0_d;
            op1_q      <= op1_d;
            arg1_q     <= arg1_d;
            pc1_q      <= pc1_d;
        end
    end

    assign MEM_RD      = mem_rd_q;
    assign MEM_ADDR    = mem_addr_q;
    assign INSTR_OUT   = op0_q;
    assign ARG_OUT     = arg0_q;
    assign PC_OUT      = pc0_q;
    assign INSTR_VALID = (count_q != 2'd0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer with a one-cycle-latency program memory
//   model, a read-address log and an expected-instruction scoreboard.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  arg;
        logic [11:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        FETCH_EN;
    logic        MEM_RD;
    logic [11:0] MEM_ADDR;
    logic [7:0]  MEM_DATA = 8'h00;
    logic        JUMP_REQ;
    logic [11:0] JUMP_ADDR;
    logic [7:0]  INSTR_OUT;
    logic [7:0]  ARG_OUT;
    logic [11:0] PC_OUT;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    logic [7:0]  mem [0:4095];
    entry_t      sb[$];
    logic [11:0] rd_log[$];
    int          n_pass = 0;
    int          n_total = 0;

    fetch_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .FETCH_EN(FETCH_EN),
        .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .JUMP_REQ(JUMP_REQ), .JUMP_ADDR(JUMP_ADDR),
        .INSTR_OUT(INSTR_OUT), .ARG_OUT(ARG_OUT), .PC_OUT(PC_OUT),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY)
    );

    always #5 clk = ~clk;

    // Program memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (MEM_RD === 1'b1) MEM_DATA <= mem[MEM_ADDR];
    end

    // Every read cycle seen by the memory, in order.
    always @(posedge clk) begin
        if (MEM_RD === 1'b1) rd_log.push_back(MEM_ADDR);
    end

    function automatic logic [7:0] mem_byte(input logic [11:0] a);
        if (a == 12'h000) return 8'h64;
        if (a == 12'h001) return 8'h03;
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    function automatic entry_t exp_entry(input logic [11:0] pc);
        entry_t e;
        e.op  = mem_byte(pc);
        e.arg = mem_byte(pc + 12'd1);
        e.pc  = pc;
        return e;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < rd_log.size()) return {20'd0, rd_log[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a head instruction, compare with the scoreboard, pop it.
    task automatic consume(input string tag);
        int n = 0;
        entry_t e;
        while (INSTR_VALID !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : entry_t'(28'h0);
        chk({tag, "_op"},  {24'd0, INSTR_OUT}, {24'd0, e.op});
        chk({tag, "_arg"}, {24'd0, ARG_OUT},   {24'd0, e.arg});
        chk({tag, "_pc"},  {20'd0, PC_OUT},    {20'd0, e.pc});
        INSTR_READY = 1'b1;
        step();
        INSTR_READY = 1'b0;
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (MEM_RD !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, MEM_RD}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},    {31'd0, MEM_RD},      32'd0);
        chk({tag, "_addr"},  {20'd0, MEM_ADDR},    32'd0);
        chk({tag, "_valid"}, {31'd0, INSTR_VALID}, 32'd0);
        chk({tag, "_op"},    {24'd0, INSTR_OUT},   32'd0);
        chk({tag, "_arg"},   {24'd0, ARG_OUT},     32'd0);
        chk({tag, "_pc"},    {20'd0, PC_OUT},      32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b0;
        FETCH_EN    = 1'b1;
        JUMP_REQ    = 1'b0;
        JUMP_ADDR   = 12'h000;
        INSTR_READY = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = mem_byte(12'(i));

        // Reset state.
        repeat (3) step();
        chk_reset_outputs("rst");

        // First instruction after release.
        sb.push_back(exp_entry(12'h000));
        if (DEPTH == 2) sb.push_back(exp_entry(12'h002));
        reset = 1'b1;
        rd_log.delete();
        step();
        chk("e1_rd",   {31'd0, MEM_RD}, 32'd1);
        chk("e1_addr", {20'd0, MEM_ADDR}, 32'h000);
        step();
        chk("e2_rd",   {31'd0, MEM_RD}, 32'd1);
        chk("e2_addr", {20'd0, MEM_ADDR}, 32'h001);
        step();
        chk("e3_rd",    {31'd0, MEM_RD}, 32'd0);
        chk("e3_hold",  {20'd0, MEM_ADDR}, 32'h001);
        chk("e3_valid", {31'd0, INSTR_VALID}, 32'd0);
        step();
        chk("e4_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("e4_op",    {24'd0, INSTR_OUT}, 32'h64);
        chk("e4_arg",   {24'd0, ARG_OUT}, 32'h03);
        chk("e4_pc",    {20'd0, PC_OUT}, 32'h000);

        // Buffer full with consumer stalled: fetching stops.
        repeat (6) step();
        chk("full_rd",   {31'd0, MEM_RD}, 32'd0);
        chk("full_head", {20'd0, PC_OUT}, 32'h000);
        consume("pop0");
        chk("after_pop_valid", {31'd0, INSTR_VALID}, (DEPTH == 2) ? 32'd1 : 32'd0);
        wait_rd("refetch_rd");
        chk("refetch_addr", {20'd0, MEM_ADDR}, (DEPTH == 2) ? 32'h004 : 32'h002);

        // Jump from a full buffer.
        repeat (8) step();
        chk("c_full_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("c_full_rd",    {31'd0, MEM_RD}, 32'd0);
        JUMP_REQ  = 1'b1;
        JUMP_ADDR = 12'h1A5;
        step();
        JUMP_REQ = 1'b0;
        rd_log.delete();
        sb.delete();
        sb.push_back(exp_entry(12'h1A4));
        chk("jmp_valid", {31'd0, INSTR_VALID}, 32'd0);
        chk("jmp_rd",    {31'd0, MEM_RD}, 32'd1);
        chk("jmp_addr",  {20'd0, MEM_ADDR}, 32'h1A4);
        consume("jmp1a4");

        // Jump to the top of memory; PC wraps to 0.
        JUMP_REQ  = 1'b1;
        JUMP_ADDR = 12'hFFE;
        step();
        JUMP_REQ = 1'b0;
        rd_log.delete();
        sb.delete();
        sb.push_back(exp_entry(12'hFFE));
        sb.push_back(exp_entry(12'h000));
        consume("wrapffe");
        consume("wrap000");
        chk("wrap_log0", log_at(0), 32'hFFE);
        chk("wrap_log1", log_at(1), 32'hFFF);
        chk("wrap_log2", log_at(2), 32'h000);
        chk("wrap_log3", log_at(3), 32'h001);

        // Jump and pop on the same edge.
        n = 0;
        while (INSTR_VALID !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("jp_pre_valid", {31'd0, INSTR_VALID}, 32'd1);
        INSTR_READY = 1'b1;
        JUMP_REQ    = 1'b1;
        JUMP_ADDR   = 12'h300;
        step();
        INSTR_READY = 1'b0;
        JUMP_REQ    = 1'b0;
        sb.delete();
        sb.push_back(exp_entry(12'h300));
        chk("jp_valid", {31'd0, INSTR_VALID}, 32'd0);
        consume("jp300");

        // Asynchronous reset in the middle of an argument fetch.
        n = 0;
        while (!(MEM_RD === 1'b1 && MEM_ADDR[0] === 1'b1) && n < 40) begin
            step();
            n++;
        end
        chk("arg_phase", {31'd0, MEM_RD & MEM_ADDR[0]}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async");
        step();
        step();
        reset = 1'b1;
        rd_log.delete();
        sb.delete();
        sb.push_back(exp_entry(12'h000));
        consume("post_rst");
        chk("post_rst_log0", log_at(0), 32'h000);
        chk("post_rst_log1", log_at(1), 32'h001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of opcode, argument and memory data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, width of program counter and memory address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port FETCH_EN  input  1  high permits new instruction fetches.
REQ-006 SHALL have port MEM_RD  output  1  program-memory read strobe.
REQ-007 SHALL have port MEM_ADDR  output  ADDR_WIDTH  program-memory byte address.
REQ-008 SHALL have port MEM_DATA  input  DATA_WIDTH  read data, valid the cycle after MEM_RD.
REQ-009 SHALL have port JUMP_REQ  input  1  redirect request from the control unit.
REQ-010 SHALL have port JUMP_ADDR  input  ADDR_WIDTH  redirect target.
REQ-011 SHALL have port INSTR_OUT  output  DATA_WIDTH  opcode at buffer head.
REQ-012 SHALL have port ARG_OUT  output  DATA_WIDTH  argument at buffer head.
REQ-013 SHALL have port PC_OUT  output  ADDR_WIDTH  address of the opcode at buffer head.
REQ-014 SHALL have port INSTR_VALID  output  1  buffer head holds a valid instruction.
REQ-015 SHALL have port INSTR_READY  input  1  consumer accepts the head instruction.

Function
REQ-016 SHALL treat each instruction as two bytes: opcode at PC, argument at PC+1.
REQ-017 SHALL implement states IDLE, FETCH_OP, FETCH_ARG, CAPTURE and WAIT.
REQ-018 SHALL move IDLE->FETCH_OP when FETCH_EN=1 and buffer count < DEPTH; otherwise it SHALL remain in IDLE.
REQ-019 SHALL, in FETCH_OP, drive MEM_RD=1 with MEM_ADDR=PC, then go to FETCH_ARG.
REQ-020 SHALL, in FETCH_ARG, drive MEM_RD=1 with MEM_ADDR=PC+1, latch MEM_DATA as the opcode, then go to CAPTURE.
REQ-021 SHALL, in CAPTURE, drive MEM_RD=0, write {opcode, MEM_DATA, PC} into the buffer tail and set PC to PC+2.
REQ-022 SHALL, after CAPTURE, go to IDLE if FETCH_EN=0; otherwise to FETCH_OP if the post-update count < DEPTH, else to WAIT.
REQ-023 SHALL, in WAIT, drive MEM_RD=0 and go to FETCH_OP once the registered count < DEPTH.
REQ-024 SHALL hold MEM_ADDR at its last value whenever MEM_RD=0.
REQ-025 SHALL decode MEM_RD and MEM_ADDR from registered state only, with no combinational path from any input.
REQ-026 SHALL let FETCH_EN=0 during FETCH_OP or FETCH_ARG complete the current instruction through CAPTURE.
REQ-027 SHALL drive INSTR_VALID=1 exactly when count != 0, with INSTR_OUT, ARG_OUT and PC_OUT taken from the oldest entry.
REQ-028 SHALL pop the head entry on a rising edge where INSTR_VALID=1 and INSTR_READY=1.
REQ-029 SHALL allow a pop and a CAPTURE write in the same cycle, leaving the count unchanged.
REQ-030 SHALL wrap PC modulo 2^ADDR_WIDTH, so that 0xFFE+2=0x000 and PC+1 of 0xFFF is 0x000.
REQ-031 SHALL, on a rising edge with JUMP_REQ=1, do all of the following: empty the buffer, set PC to JUMP_ADDR with bit 0 forced to 0, discard any in-flight opcode or argument, and enter FETCH_OP if FETCH_EN=1, else IDLE.
REQ-032 SHALL give JUMP_REQ priority over any pop or CAPTURE write on the same edge; no pre-jump entry may become visible afterwards.
REQ-033 SHALL guarantee that CAPTURE never writes into a full buffer.

Reset
REQ-034 SHALL, while reset=0 and regardless of clk, force the following: state=IDLE, PC=0, count=0, MEM_RD=0, MEM_ADDR=0, INSTR_VALID=0, INSTR_OUT=0, ARG_OUT=0, PC_OUT=0.
REQ-035 SHALL abandon any fetch in progress when reset asserts and restart from PC=0 after release.

Configuration
REQ-036 SHALL set buffer DEPTH=2 (prefetch) when macro FETCH_PREFETCH_EN is defined.
REQ-037 SHALL set DEPTH=1 when FETCH_PREFETCH_EN is undefined, so the next fetch starts only after the head entry is popped; all other behaviour is identical.

Verification
REQ-038 SHALL cover: mem[0]=0x64, mem[1]=0x03, FETCH_EN=1 at reset release -> MEM_RD at addr 0x000 then 0x001; INSTR_VALID=1 with INSTR_OUT=0x64, ARG_OUT=0x03, PC_OUT=0x000 on the 4th edge.
REQ-039 SHALL cover: INSTR_READY=0, FETCH_PREFETCH_EN defined -> two entries with PC 0x000 and 0x002 buffered, then state WAIT with MEM_RD=0; a single pop -> a fetch at 0x004 follows.
REQ-040 SHALL cover: buffer full, JUMP_REQ=1 with JUMP_ADDR=0x1A5 -> INSTR_VALID=0 after the edge, next MEM_ADDR=0x1A4, first delivered PC_OUT=0x1A4.
REQ-041 SHALL cover: jump to 0xFFE with READY=1 -> PC_OUT=0xFFE delivered, next opcode fetch at MEM_ADDR=0x000.
REQ-042 SHALL cover: JUMP_REQ and a pop on the same edge -> count=0 afterwards and no stale PC_OUT appears.
REQ-043 SHALL cover: reset driven low mid-FETCH_ARG, between clock edges -> all outputs reach their reset values immediately, and after release the first fetch is at 0x000.
